uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Byte-to-serial UART transmitter for the memory/IO subsystem; the sending end of the link timed by the divider (868 clk/bit = 115200 baud @ 100 MHz).
//  Uses an internal baud counter on the system clock rather than a divided clock, so the whole block sits in one clock domain.
//  Accepts a byte through a valid/ready handshake and emits one frame on o_tx: start bit, LSB-first data, optional parity, stop bit(s).
// PARAMETERS
//  CLKS_PER_BIT  868  system clocks per serial bit; legal range >= 2
//  DATA_BITS     8    data bits per frame; legal range 5..8
//  PARITY_EN     0    1 = append a parity bit after the data bits
//  PARITY_ODD    0    used only when PARITY_EN=1: 1 = odd parity, 0 = even parity
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  i_clk       in   1          system clock; every register is clocked on its rising edge
//  i_rst       in   1          asynchronous reset, active-high
//  i_tx_data   in   DATA_BITS  byte to send; sampled only on a handshake
//  i_tx_valid  in   1          upstream offers i_tx_data
//  o_tx_ready  out  1          block can accept a byte; high only in IDLE
//  o_tx        out  1          serial line; idles at 1
//  o_busy      out  1          a frame is in progress (any state except IDLE)
// BEHAVIOUR
//  Reset (async, i_rst=1):
//   - o_tx=1, o_tx_ready=1, o_busy=0, FSM=IDLE, all counters=0.
//   - If asserted mid-frame, the frame is aborted and o_tx returns to 1 immediately, with no clock edge needed.
//  Handshake:
//   - A transfer occurs on the rising edge where i_tx_valid & o_tx_ready are both 1.
//   - i_tx_data is copied into the shift register on that edge.
//   - On the next cycle: START state, o_tx=0, o_tx_ready=0, o_busy=1.
//   - i_tx_valid and i_tx_data are ignored outside IDLE; changing them mid-frame does not alter the frame.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Each bit lasts exactly CLKS_PER_BIT cycles.
//   - The baud counter restarts at 0 on entry to every bit and raises its tick on count CLKS_PER_BIT-1.
//   - DATA: o_tx = shreg[0]; the register shifts right on each tick; the bit counter runs 0..DATA_BITS-1.
//     On the tick where the count is DATA_BITS-1, go to PARITY if PARITY_EN, otherwise STOP.
//   - PARITY: o_tx = ^data, XOR-ed with PARITY_ODD. The parity is computed from the latched byte, not the shifted register.
//   - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  Frame length, handshake edge to IDLE: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
//  Back-to-back frames: o_tx_ready rises in the first IDLE cycle.
//   - If i_tx_valid is held, the next start bit begins on the following cycle.
//   - The line therefore sits at 1 for exactly 1 extra cycle between frames.
//  Widths:
//   - Baud counter: $clog2(CLKS_PER_BIT) bits.
//   - Bit counter: 3 bits.
//   - Counters never wrap past their terminal value; each is cleared on its tick.
//  o_tx is registered, so there is no combinational path from inputs to o_tx.
//  o_tx_ready and o_busy are decoded directly from the state register.
// STRUCTURE
//  Shared header uart_defs.vh:
//   - FSM state encodings ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
//   - UART_CLKS_115200 = 868.
//   - The frame-length macro.
//  One sub-module, uart_baud_tick (params CLKS_PER_BIT):
//   - Ports: i_clk, i_rst, i_restart, o_tick.
//   - The counter is cleared by i_restart or by its own tick.
//   - Shared with the receiver-side logic.
//  The top level holds the FSM, shift register, bit counter, parity bit and o_tx register.
// TESTING  (bench uses CLKS_PER_BIT=4, DATA_BITS=8 unless noted)
//  1. Reset: pulse i_rst with no clock edge.
//     -> o_tx=1, o_tx_ready=1, o_busy=0 immediately.
//  2. Single byte, no parity, 1 stop: send 0xA5.
//     -> o_tx = 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4.
//     -> o_tx_ready high again 40 cycles after the handshake edge.
//  3. Back-to-back: hold i_tx_valid with 0x00, then 0xFF.
//     -> Second start bit begins exactly 1 cycle after the first stop bit ends.
//     -> Both frames are bit-exact.
//  4. Parity: PARITY_EN=1, send 0x07.
//     -> PARITY_ODD=0: parity bit 1.
//     -> PARITY_ODD=1: parity bit 0.
//     -> Frame is 44 cycles in both cases.
//  5. Mid-frame reset: assert i_rst during data bit 3 of 0x3C.
//     -> o_tx=1 in the same cycle.
//     -> After release, ready=1 and a fresh 0x5A transmits correctly.
//  6. Busy-time noise: toggle i_tx_valid and randomize i_tx_data during a 0x81 frame.
//     -> Serial output is still 0x81.
//     -> No second frame unless valid is high while in IDLE.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings, the
// standard 115200-baud divider and the frame-length helper.
package uart_tx_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned UART_CLKS_115200 = 868;

   // Clock cycles from the handshake edge until the transmitter is idle again
   function automatic int unsigned uart_frame_cycles(
      input int unsigned clks_per_bit,
      input int unsigned data_bits,
      input int unsigned parity_en,
      input int unsigned stop_bits
   );
      return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period timer: pulses o_tick on the last clock of every serial bit.
// Shared by the transmit and receive sides of the link.
module uart_baud_tick
   import uart_tx_serializer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_115200
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt;

   assign o_tick = (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (i_restart || o_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: valid/ready byte input, one frame of
// start, LSB-first data, optional parity and stop bit(s) on o_tx.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_115200,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       PAR_ODD   = (PARITY_ODD != 0);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] shreg, shreg_next;
   logic [2:0]           bit_cnt, bit_cnt_next;
   logic                 par, par_next;
   logic                 tx_next;
   logic                 tick;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (state == ST_IDLE),
      .o_tick    (tick)
   );

   assign o_tx_ready = (state == ST_IDLE);
   assign o_busy     = (state != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         o_tx    <= 1'b1;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_cnt <= bit_cnt_next;
         par     <= par_next;
         o_tx    <= tx_next;
      end
   end

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
      par_next     = par;
      tx_next      = 1'b1;

      case (state)
         ST_IDLE: begin
            if (i_tx_valid) begin
               state_next   = ST_START;
               shreg_next   = i_tx_data;
               par_next     = (^i_tx_data) ^ PAR_ODD;
               bit_cnt_next = '0;
            end
         end
         ST_START: begin
            if (tick) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               shreg_next = shreg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) state_next = ST_STOP;
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_next = '0;
                  state_next   = ST_IDLE;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // o_tx is registered from the next-state decode so the line moves on the same edge as the FSM
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shreg_next[0];
         ST_PARITY: tx_next = par_next;
         default:   tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at 4 clocks per bit: a plain
// instance and two parity instances (even / odd), byte-level scoreboard.
module tb_uart_tx_serializer;

   localparam int unsigned CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = '0;
   logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
   logic       ready0, ready1, ready2;
   logic       tx0, tx1, tx2;
   logic       busy0, busy1, busy2;

   int         checks = 0;
   int         passed = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid0),
      .o_tx_ready(ready0), .o_tx(tx0), .o_busy(busy0)
   );

   uart_tx_serializer #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
   ) dut_pe (
      .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid1),
      .o_tx_ready(ready1), .o_tx(tx1), .o_busy(busy1)
   );

   uart_tx_serializer #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
   ) dut_po (
      .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid2),
      .o_tx_ready(ready2), .o_tx(tx2), .o_busy(busy2)
   );

   function automatic logic get_tx(input int sel);
      case (sel)
         0: return tx0;
         1: return tx1;
         default: return tx2;
      endcase
   endfunction

   function automatic logic get_ready(input int sel);
      case (sel)
         0: return ready0;
         1: return ready1;
         default: return ready2;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   task automatic set_valid(input int sel, input logic v);
      case (sel)
         0: valid0 = v;
         1: valid1 = v;
         default: valid2 = v;
      endcase
   endtask

   // Offer a byte, wait (bounded) for the handshake edge; returns at edge+1.
   task automatic send(input int sel, input logic [7:0] b, input bit hold);
      int n;
      n = 0;
      @(posedge clk); #1;
      data = b;
      set_valid(sel, 1'b1);
      exp_q.push_back(b);
      while (get_ready(sel) !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 200) $display("FAIL send_timeout dut%0d: ready never seen, byte %h", sel, b);
      else passed++;
      @(posedge clk); #1;
      if (!hold) set_valid(sel, 1'b0);
   endtask

   // Starts right after a handshake edge; checks every cycle of every bit,
   // the frame length, and the first idle cycle after the frame.
   task automatic recv_frame(input int sel, input int pe, input int po, input string tag);
      logic [7:0]  b;
      logic [11:0] bits;
      int          nb;
      logic        bad, got;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL %s: scoreboard empty, no expected byte", tag);
         return;
      end
      b = exp_q.pop_front();
      bits = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
      nb = 9;
      if (pe != 0) begin
         bits[nb] = (^b) ^ po[0];
         nb++;
      end
      bits[nb] = 1'b1;
      nb++;
      for (int k = 0; k < nb; k++) begin
         bad = 1'b0;
         got = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (get_tx(sel) !== bits[k]) begin
               bad = 1'b1;
               got = get_tx(sel);
            end
         end
         checks++;
         if (bad) $display("FAIL %s bit%0d (byte %h): o_tx=%b required %b", tag, k, b, got, bits[k]);
         else passed++;
      end
      checks++;
      if (get_ready(sel) !== 1'b0 || get_busy(sel) !== 1'b1)
         $display("FAIL %s last_cycle: ready=%b busy=%b required ready=0 busy=1", tag, get_ready(sel), get_busy(sel));
      else passed++;
      @(negedge clk);
      checks++;
      if ({get_ready(sel), get_busy(sel), get_tx(sel)} !== 3'b101)
         $display("FAIL %s idle_after: ready=%b busy=%b tx=%b required 1 0 1", tag, get_ready(sel), get_busy(sel), get_tx(sel));
      else passed++;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({get_tx(s), get_ready(s), get_busy(s)} !== 3'b110)
            $display("FAIL reset dut%0d: tx=%b ready=%b busy=%b required 1 1 0", s, get_tx(s), get_ready(s), get_busy(s));
         else passed++;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      send(0, 8'hA5, 1'b0);
      recv_frame(0, 0, 0, "single_A5");
   endtask

   task automatic test_back_to_back();
      send(0, 8'h00, 1'b1);
      data = 8'hFF;
      exp_q.push_back(8'hFF);
      recv_frame(0, 0, 0, "b2b_first");
      fork
         begin
            @(posedge clk); #1;
            valid0 = 1'b0;
         end
      join_none
      recv_frame(0, 0, 0, "b2b_second");
      checks++;
      if (ready0 !== 1'b1 || busy0 !== 1'b0)
         $display("FAIL b2b_no_third: ready=%b busy=%b required 1 0", ready0, busy0);
      else passed++;
   endtask

   task automatic test_parity();
      send(1, 8'h07, 1'b0);
      recv_frame(1, 1, 0, "parity_even_07");
      send(2, 8'h07, 1'b0);
      recv_frame(2, 1, 1, "parity_odd_07");
   endtask

   task automatic test_mid_reset();
      send(0, 8'h3C, 1'b0);
      repeat (18) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (tx0 !== 1'b1) $display("FAIL midreset_tx: o_tx=%b required 1", tx0);
      else passed++;
      checks++;
      if (ready0 !== 1'b1 || busy0 !== 1'b0)
         $display("FAIL midreset_state: ready=%b busy=%b required 1 0", ready0, busy0);
      else passed++;
      void'(exp_q.pop_front());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1) $display("FAIL midreset_release: ready=%b required 1", ready0);
      else passed++;
      send(0, 8'h5A, 1'b0);
      recv_frame(0, 0, 0, "after_reset_5A");
   endtask

   task automatic test_busy_noise();
      logic bad;
      send(0, 8'h81, 1'b0);
      fork
         begin
            repeat (30) begin
               @(posedge clk); #1;
               valid0 = 1'($urandom_range(0, 1));
               data   = 8'($urandom);
            end
            valid0 = 1'b0;
         end
         recv_frame(0, 0, 0, "noise_81");
      join
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL noise_no_extra_frame: busy=%b tx=%b required 0 1", busy0, tx0);
      else passed++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_mid_reset();
      test_busy_noise();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
